// File: rtl/display_pkg.sv
// Shared constants for the seven-segment display decoder: segment patterns,
// pattern class encoding and the settle/locked state encoding.
package display_pkg;

    // Active-low segment patterns, bit order gfedcba
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_IDLE = 7'b0111111;
    localparam logic [6:0] SEG_ERR  = 7'b0110110;

    localparam logic [3:0] DIG_SEL_DEFAULT = 4'b1110;

    localparam int NUM_DIGITS = 6;

    typedef enum logic [1:0] {
        CLS_DIGIT   = 2'd0,
        CLS_IDLE    = 2'd1,
        CLS_ERR     = 2'd2,
        CLS_UNKNOWN = 2'd3
    } seg_class_e;

    localparam logic [0:0] ST_SETTLE = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Increment that sticks at the all-ones value
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/seg7_classify.sv
// Combinational classifier: maps an active-low segment pattern to its class
// and, for digits, the 0-5 index.
module seg7_classify
    import display_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic [1:0] seg_class,
    output logic [2:0] value
);

    always_comb begin
        seg_class = CLS_UNKNOWN;
        value     = 3'd0;
        case (seg_n)
            SEG_0: begin seg_class = CLS_DIGIT; value = 3'd0; end
            SEG_1: begin seg_class = CLS_DIGIT; value = 3'd1; end
            SEG_2: begin seg_class = CLS_DIGIT; value = 3'd2; end
            SEG_3: begin seg_class = CLS_DIGIT; value = 3'd3; end
            SEG_4: begin seg_class = CLS_DIGIT; value = 3'd4; end
            SEG_5: begin seg_class = CLS_DIGIT; value = 3'd5; end
            SEG_IDLE: seg_class = CLS_IDLE;
            SEG_ERR:  seg_class = CLS_ERR;
            default:  seg_class = CLS_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/display_decoder.sv
// Receive-side seven-segment decoder: registers the digit frame, waits for it
// to be stable for STABLE_CYCLES samples, then classifies each new frame.
module display_decoder
    import display_pkg::*;
#(
    parameter int         STABLE_CYCLES = 4,
    parameter logic [3:0] DIG_SEL       = DIG_SEL_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] L_in,
    input  logic [3:0] Dig_in,
    input  logic       H_in,
    output logic [2:0] value_out,
    output logic [5:0] onehot_out,
    output logic       idle,
    output logic       err,
    output logic       unknown,
    output logic       dp,
    output logic       valid,
    output logic [7:0] frame_cnt
);

    localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

    logic [11:0] sample;
    logic [11:0] r_q, r_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [0:0]  state_q, state_d;
    logic [7:0]  last_q, last_d;
    logic        last_vld_q, last_vld_d;
    logic [2:0]  value_q, value_d;
    logic [5:0]  onehot_q, onehot_d;
    logic        idle_q, idle_d;
    logic        err_q, err_d;
    logic        unknown_q, unknown_d;
    logic        dp_q, dp_d;
    logic        valid_q, valid_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;

    logic [1:0]  cls;
    logic [2:0]  cls_value;
    logic [5:0]  onehot_dec;
    logic        frame_sel;
    logic        same;
    logic        accept;

    assign sample    = {Dig_in, H_in, L_in};
    assign frame_sel = (Dig_in == DIG_SEL);
    assign same      = (sample == r_q);

    seg7_classify u_classify (
        .seg_n     (L_in),
        .seg_class (cls),
        .value     (cls_value)
    );

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_onehot
        assign onehot_dec[gi] = (cls == CLS_DIGIT) && (cls_value == 3'(gi));
    end

    // Stability counter and settle/locked tracking
    always_comb begin
        r_d     = sample;
        cnt_d   = cnt_q;
        state_d = state_q;
        accept  = 1'b0;
        if (!frame_sel) begin
            cnt_d   = 8'd0;
            state_d = ST_SETTLE;
        end else begin
            if (!same) begin
                cnt_d = 8'd1;
            end else if (cnt_q < STABLE_LIM) begin
                cnt_d = cnt_q + 8'd1;
            end
            case (state_q)
                ST_SETTLE: begin
                    if (cnt_d == STABLE_LIM) begin
                        state_d = ST_LOCKED;
                        // Re-settling on the frame already reported stays silent
                        accept = !last_vld_q || ({H_in, L_in} != last_q);
                    end
                end
                default: begin
                    if (!same) begin
                        state_d = ST_SETTLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        last_d      = last_q;
        last_vld_d  = last_vld_q;
        value_d     = value_q;
        onehot_d    = onehot_q;
        idle_d      = idle_q;
        err_d       = err_q;
        unknown_d   = unknown_q;
        dp_d        = dp_q;
        valid_d     = 1'b0;
        frame_cnt_d = frame_cnt_q;
        if (accept) begin
            last_d      = {H_in, L_in};
            last_vld_d  = 1'b1;
            value_d     = (cls == CLS_DIGIT) ? cls_value : 3'd0;
            onehot_d    = onehot_dec;
            idle_d      = (cls == CLS_IDLE);
            err_d       = (cls == CLS_ERR);
            unknown_d   = (cls == CLS_UNKNOWN);
            dp_d        = ~H_in;
            valid_d     = 1'b1;
            frame_cnt_d = sat_inc8(frame_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q         <= 12'd0;
            cnt_q       <= 8'd0;
            state_q     <= ST_SETTLE;
            last_q      <= 8'd0;
            last_vld_q  <= 1'b0;
            value_q     <= 3'd0;
            onehot_q    <= 6'd0;
            idle_q      <= 1'b0;
            err_q       <= 1'b0;
            unknown_q   <= 1'b0;
            dp_q        <= 1'b0;
            valid_q     <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            last_q      <= last_d;
            last_vld_q  <= last_vld_d;
            value_q     <= value_d;
            onehot_q    <= onehot_d;
            idle_q      <= idle_d;
            err_q       <= err_d;
            unknown_q   <= unknown_d;
            dp_q        <= dp_d;
            valid_q     <= valid_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign value_out  = value_q;
    assign onehot_out = onehot_q;
    assign idle       = idle_q;
    assign err        = err_q;
    assign unknown    = unknown_q;
    assign dp         = dp_q;
    assign valid      = valid_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_display_decoder.sv
// Directed bench for display_decoder: a vector table of held frames plus
// hand-written sequences for latency, discard, mid-settle reset and saturation.
module tb_display_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] L_in;
    logic [3:0] Dig_in;
    logic       H_in;
    logic [2:0] value_out;
    logic [5:0] onehot_out;
    logic       idle, err, unknown, dp, valid;
    logic [7:0] frame_cnt;

    int n_vec = 0;
    int n_err = 0;

    display_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .L_in       (L_in),
        .Dig_in     (Dig_in),
        .H_in       (H_in),
        .value_out  (value_out),
        .onehot_out (onehot_out),
        .idle       (idle),
        .err        (err),
        .unknown    (unknown),
        .dp         (dp),
        .valid      (valid),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] l;
        logic [3:0] dig;
        logic       h;
        int         hold;
        logic [2:0] val;
        logic [5:0] oh;
        logic       idl;
        logic       er;
        logic       unk;
        logic       dpx;
        int         nvalid;
        logic [7:0] fc;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic [6:0] l, input logic [3:0] dig, input logic h,
                                input int hold, input logic [2:0] val, input logic [5:0] oh,
                                input logic idl, input logic er, input logic unk, input logic dpx,
                                input int nvalid, input logic [7:0] fc);
        vec_t v;
        v.l = l; v.dig = dig; v.h = h; v.hold = hold; v.val = val; v.oh = oh;
        v.idl = idl; v.er = er; v.unk = unk; v.dpx = dpx; v.nvalid = nvalid; v.fc = fc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock, sampling outputs on the following falling edge
    task automatic tick(output logic v);
        @(posedge clk);
        @(negedge clk);
        v = valid;
    endtask

    task automatic chk_outs(input string tag, input logic [2:0] val, input logic [5:0] oh,
                            input logic idl, input logic er, input logic unk,
                            input logic dpx, input logic [7:0] fc);
        chk({tag, ".value"},   32'(value_out),  32'(val));
        chk({tag, ".onehot"},  32'(onehot_out), 32'(oh));
        chk({tag, ".idle"},    32'(idle),       32'(idl));
        chk({tag, ".err"},     32'(err),        32'(er));
        chk({tag, ".unknown"}, 32'(unknown),    32'(unk));
        chk({tag, ".dp"},      32'(dp),         32'(dpx));
        chk({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(fc));
    endtask

    initial begin
        logic v;
        int   nv;

        // Frames applied in order after the first digit-0 acceptance (frame_cnt=1)
        vecs[0]  = mk(7'b0010010, 4'b1110, 1'b1, 6, 3'd5, 6'b100000, 0, 0, 0, 0, 1, 8'd2);
        vecs[1]  = mk(7'b1111001, 4'b1110, 1'b1, 1, 3'd5, 6'b100000, 0, 0, 0, 0, 0, 8'd2);
        vecs[2]  = mk(7'b0010010, 4'b1110, 1'b1, 6, 3'd5, 6'b100000, 0, 0, 0, 0, 0, 8'd2);
        vecs[3]  = mk(7'b0111111, 4'b1110, 1'b1, 6, 3'd0, 6'b000000, 1, 0, 0, 0, 1, 8'd3);
        vecs[4]  = mk(7'b0110110, 4'b1110, 1'b1, 6, 3'd0, 6'b000000, 0, 1, 0, 0, 1, 8'd4);
        vecs[5]  = mk(7'b0000000, 4'b1110, 1'b0, 6, 3'd0, 6'b000000, 0, 0, 1, 1, 1, 8'd5);
        vecs[6]  = mk(7'b1111001, 4'b1110, 1'b1, 5, 3'd1, 6'b000010, 0, 0, 0, 0, 1, 8'd6);
        vecs[7]  = mk(7'b0100100, 4'b1110, 1'b1, 4, 3'd2, 6'b000100, 0, 0, 0, 0, 1, 8'd7);
        vecs[8]  = mk(7'b0110000, 4'b1110, 1'b1, 4, 3'd3, 6'b001000, 0, 0, 0, 0, 1, 8'd8);
        vecs[9]  = mk(7'b0011001, 4'b1110, 1'b0, 4, 3'd4, 6'b010000, 0, 0, 0, 1, 1, 8'd9);
        vecs[10] = mk(7'b0011001, 4'b1110, 1'b1, 4, 3'd4, 6'b010000, 0, 0, 0, 0, 1, 8'd10);
        vecs[11] = mk(7'b1000000, 4'b1111, 1'b1, 5, 3'd4, 6'b010000, 0, 0, 0, 0, 0, 8'd10);
        vecs[12] = mk(7'b1000000, 4'b1110, 1'b1, 3, 3'd4, 6'b010000, 0, 0, 0, 0, 0, 8'd10);
        vecs[13] = mk(7'b1000000, 4'b1110, 1'b1, 1, 3'd0, 6'b000001, 0, 0, 0, 0, 1, 8'd11);
        vecs[14] = mk(7'b1000000, 4'b1111, 1'b1, 1, 3'd0, 6'b000001, 0, 0, 0, 0, 0, 8'd11);
        vecs[15] = mk(7'b1000000, 4'b1110, 1'b1, 6, 3'd0, 6'b000001, 0, 0, 0, 0, 0, 8'd11);

        reset = 1'b1; L_in = 7'b1111111; Dig_in = 4'b1111; H_in = 1'b1;
        repeat (2) tick(v);
        chk_outs("reset", 3'd0, 6'd0, 0, 0, 0, 0, 8'd0);
        chk("reset.valid", 32'(valid), 32'd0);
        $display("reset: value=%0d onehot=%b frame_cnt=%0d", value_out, onehot_out, frame_cnt);

        // Digit 0 from the first edge after release: valid exactly at edge 4
        reset = 1'b0; L_in = 7'b1000000; Dig_in = 4'b1110; H_in = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick(v);
            chk($sformatf("first.valid_edge%0d", i), 32'(v), (i == 4) ? 32'd1 : 32'd0);
        end
        chk_outs("first", 3'd0, 6'b000001, 0, 0, 0, 0, 8'd1);
        $display("first: value=%0d onehot=%b dp=%0d frame_cnt=%0d", value_out, onehot_out, dp, frame_cnt);

        for (int k = 0; k < 16; k++) begin
            L_in = vecs[k].l; Dig_in = vecs[k].dig; H_in = vecs[k].h;
            nv = 0;
            for (int c = 0; c < vecs[k].hold; c++) begin
                tick(v);
                if (v) nv++;
            end
            chk($sformatf("vec%0d.nvalid", k), 32'(nv), 32'(vecs[k].nvalid));
            chk_outs($sformatf("vec%0d", k), vecs[k].val, vecs[k].oh, vecs[k].idl,
                     vecs[k].er, vecs[k].unk, vecs[k].dpx, vecs[k].fc);
            $display("vec %0d: L=%b Dig=%b H=%b -> value=%0d onehot=%b idle=%0d err=%0d unk=%0d dp=%0d valids=%0d frame_cnt=%0d",
                     k, vecs[k].l, vecs[k].dig, vecs[k].h, value_out, onehot_out, idle, err,
                     unknown, dp, nv, frame_cnt);
        end

        // Deselected digit with segments toggling: nothing may be accepted
        Dig_in = 4'b1111; H_in = 1'b1;
        nv = 0;
        for (int c = 0; c < 20; c++) begin
            L_in = (c % 2 == 0) ? 7'b1111001 : 7'b0100100;
            tick(v);
            if (v) nv++;
        end
        chk("toggle.nvalid", 32'(nv), 32'd0);
        chk_outs("toggle", 3'd0, 6'b000001, 0, 0, 0, 0, 8'd11);
        $display("toggle: valids=%0d value=%0d frame_cnt=%0d", nv, value_out, frame_cnt);

        // Reset after three stable samples, then a full settle is required again
        L_in = 7'b0110000; Dig_in = 4'b1110; H_in = 1'b1;
        repeat (3) tick(v);
        reset = 1'b1;
        tick(v);
        chk_outs("midreset", 3'd0, 6'd0, 0, 0, 0, 0, 8'd0);
        chk("midreset.valid", 32'(valid), 32'd0);
        reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick(v);
            chk($sformatf("midreset.valid_edge%0d", i), 32'(v), (i == 4) ? 32'd1 : 32'd0);
        end
        chk_outs("midreset.after", 3'd3, 6'b001000, 0, 0, 0, 0, 8'd1);
        $display("midreset: value=%0d frame_cnt=%0d", value_out, frame_cnt);

        // 300 alternating frames: every one accepted, counter sticks at 255
        nv = 0;
        for (int f = 0; f < 300; f++) begin
            L_in = (f % 2 == 0) ? 7'b1000000 : 7'b1111001;
            repeat (4) begin
                tick(v);
                if (v) nv++;
            end
        end
        chk("sat.nvalid", 32'(nv), 32'd300);
        chk_outs("sat", 3'd1, 6'b000010, 0, 0, 0, 0, 8'd255);
        $display("saturate: valids=%0d frame_cnt=%0d", nv, frame_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/display_decoder.md
# display_decoder

Sequential receive-side counterpart of the six-line display encoder. It samples a single active-low seven-segment digit (segments, digit strobe, decimal point), filters it for stability, and classifies each newly stable pattern as digit 0–5, idle dash, error bars or unknown. It then recovers the original 3-bit index and 6-bit one-hot line vector. It is used for on-board loopback checks and to feed panel-driven control logic.

## Interface
- STABLE_CYCLES, 4, consecutive identical samples needed to accept a frame (range 2–255)
- DIG_SEL, 4'b1110, active-low digit strobe value that marks the decoded digit
- clk  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high reset
- L_in  in  7  segments, active-low, bit0=a … bit6=g
- Dig_in  in  4  digit strobes, active-low
- H_in  in  1  decimal point, active-low
- value_out  out  3  recovered index 0–5
- onehot_out  out  6  1 << value_out when a digit is decoded, else 0
- idle  out  1  accepted frame is the idle dash
- err  out  1  accepted frame is the error pattern
- unknown  out  1  accepted frame matches no legal pattern
- dp  out  1  decimal point of accepted frame, active-high
- valid  out  1  one-cycle pulse on each acceptance
- frame_cnt  out  8  accepted-frame counter, saturating at 255

## Operation
- Legal patterns (L, active-low, gfedcba):
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - IDLE = 0111111
  - ERR = 0110110
- Input frame {Dig_in, H_in, L_in} (12 bits) is registered into `r` every clock edge.
- Frames with Dig_in ≠ DIG_SEL are discarded:
  - stability counter forced to 0;
  - FSM returns to SETTLE;
  - outputs hold.
- Stability counter `cnt`:
  - cleared to 1 when the new sample ≠ r;
  - otherwise increments, saturating at STABLE_CYCLES.
- FSM states: SETTLE → LOCKED.
  - SETTLE: when cnt reaches STABLE_CYCLES, the frame is accepted if it differs from the last accepted frame (or none has been accepted since reset); go to LOCKED.
  - LOCKED: any sample differing from r returns the FSM to SETTLE.
  - Re-stabilising on the frame already accepted produces no valid.
- On acceptance (all outputs registered on the same edge):
  - digit d: value_out=d, onehot_out=1<<d, idle=err=unknown=0;
  - IDLE: idle=1, value_out=0, onehot_out=0;
  - ERR: err=1, value_out=0, onehot_out=0;
  - anything else: unknown=1, value_out=0, onehot_out=0;
  - dp = ~H_in;
  - valid=1 for one cycle;
  - frame_cnt+1, saturating at 255.
- Exactly one of {digit, idle, err, unknown} holds after the first acceptance.

## Timing
- Reset values: value_out=0, onehot_out=0, idle=0, err=0, unknown=0, dp=0, valid=0, frame_cnt=0, FSM=SETTLE, cnt=0, last-accepted=none.
- Latency:
  - frame first sampled at edge k and held through edge k+STABLE_CYCLES−1 → outputs and valid update at edge k+STABLE_CYCLES−1;
  - with the default, a frame applied before edge 1 gives valid high in the cycle after edge 4.
- A glitch shorter than STABLE_CYCLES samples never produces valid and never disturbs held outputs.
- Reset asserted mid-settle: next edge restores all reset values; the count restarts from 0 after release.
- Frame change on the acceptance edge: the new frame is sampled, cnt=1, and acceptance of the old frame still completes.

## Structure
- Shared package `display_pkg` holds:
  - SEG_0…SEG_5, SEG_IDLE, SEG_ERR, DIG_SEL default;
  - the 2-bit class encoding (DIGIT, IDLE, ERR, UNKNOWN);
  - the FSM state encoding.
- One combinational sub-module, `seg7_classify`: L_in → class and value. It is reused by the encoder bench as a golden model.
- Top holds the input register, stability counter, FSM, output registers and frame_cnt.

## Test plan
- Reset, then L_in=1000000, Dig_in=1110, H_in=1 held 8 cycles → exactly one valid (edge 4), value_out=0, onehot_out=000001, dp=0, frame_cnt=1.
- Accept L_in=0010010 (5), then a 1-cycle glitch 1111001, then back to 0010010 → value_out=5, onehot_out=100000, no second valid, frame_cnt unchanged.
- L_in=0111111 stable → idle=1, onehot_out=0; then L_in=0110110 stable → err=1, idle=0, two valid pulses total.
- L_in=0000000 (an "8") with H_in=0 → unknown=1, dp=1, value_out=0.
- Dig_in=1111 with L_in toggling between legal digits for 20 cycles → no valid, outputs hold.
- Reset pulsed at cnt=3 → all outputs at reset values, then a full STABLE_CYCLES wait is needed.
- 300 alternating stable frames → frame_cnt saturates at 255.
